nonce_collector: RTL and testbench

Harvests winning nonces from the hash macros and queues them for the host. Watches each macro's `DATA_AVAILABLE` for rising edges, arbitrates round-robin among pending macros, and reads the 4-byte nonce over the shared macro read bus (`MACRO_RD_SELECT`/`HASH_ADDR`/`DATA_FROM_HASH`). Pushes {macro id, nonce} into a small FIFO that the register bank pops, and raises an interrupt while results are queued. Sits between the hash macro array and the register bank in the SPI clock domain.

---
 rtl/nonce_collector.sv | 197 +++++++++++++++++++
 tb/tb_nonce_collector.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_collector.sv
// nonce_collector
// Harvests winning nonces from the hash macro array and queues them for the
// register bank. A rising edge on a macro's DATA_AVAILABLE marks it pending.
// Pending macros are served round-robin. The 4-byte nonce is read over the
// shared macro read bus, and {macro id, nonce} is pushed into a small FIFO.
// irq stays high while the FIFO holds entries.
//
// Ports:
//   SPI_CLK, RST          clock, synchronous active-high reset
//   DATA_AVAILABLE        per-macro result-ready level
//   DATA_FROM_HASH        read data, valid one cycle after select/address
//   MACRO_RD_SELECT       one-hot macro read select, zero when idle
//   HASH_ADDR             macro read address, zero when idle
//   bus_req / bus_gnt     shared read bus request / grant
//   result_valid          FIFO non-empty
//   result_nonce/_macro   head entry (zero when empty)
//   result_pop            pop head entry, ignored when empty
//   fifo_count            number of queued entries
//   overflow              sticky "result dropped" flag, overflow_clear clears it
//   irq                   registered (fifo_count != 0)
module nonce_collector #(
    parameter int         NUMBER_OF_MACROS = 4,
    parameter int         ID_W             = 2,
    parameter int         FIFO_DEPTH       = 4,
    parameter int         COUNT_W          = 3,
    parameter logic [5:0] NONCE_BASE       = 6'h3C
) (
    input  logic                        SPI_CLK,
    input  logic                        RST,
    input  logic [NUMBER_OF_MACROS-1:0] DATA_AVAILABLE,
    input  logic [7:0]                  DATA_FROM_HASH,
    output logic [NUMBER_OF_MACROS-1:0] MACRO_RD_SELECT,
    output logic [5:0]                  HASH_ADDR,
    output logic                        bus_req,
    input  logic                        bus_gnt,
    output logic                        result_valid,
    output logic [31:0]                 result_nonce,
    output logic [ID_W-1:0]             result_macro,
    input  logic                        result_pop,
    output logic [COUNT_W-1:0]          fifo_count,
    output logic                        overflow,
    input  logic                        overflow_clear,
    output logic                        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, READ, PUSH} state_t;

    state_t                      state;
    logic [NUMBER_OF_MACROS-1:0] avail_q;
    logic [NUMBER_OF_MACROS-1:0] pending;
    logic [NUMBER_OF_MACROS-1:0] rise;
    logic [NUMBER_OF_MACROS-1:0] cur_mask;
    logic [NUMBER_OF_MACROS-1:0] clear_mask;
    logic [ID_W-1:0]             cur;
    logic [ID_W-1:0]             last_served;
    logic [ID_W-1:0]             pick;
    logic                        pick_found;
    logic [2:0]                  step;
    logic [31:0]                 nonce;
    logic                        drive;

    logic [ID_W+31:0]            mem [FIFO_DEPTH];
    logic [AW:0]                 wptr;
    logic [AW:0]                 rptr;
    logic [AW:0]                 wptr_next;
    logic [AW:0]                 rptr_next;
    logic                        empty;
    logic                        full;
    logic                        do_pop;
    logic                        do_push;
    logic                        drop;

    assign rise       = DATA_AVAILABLE & ~avail_q;
    assign cur_mask   = NUMBER_OF_MACROS'(1) << cur;
    assign clear_mask = (state == PUSH) ? cur_mask : '0;

    // Round-robin pick: first pending macro searching upward from the one
    // after last_served, wrapping around.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        for (int off = 1; off <= NUMBER_OF_MACROS; off++) begin
            for (int j = 0; j < NUMBER_OF_MACROS; j++) begin
                if (!pick_found && pending[j] &&
                    j == (int'(last_served) + off) % NUMBER_OF_MACROS) begin
                    pick_found = 1'b1;
                    pick       = ID_W'(j);
                end
            end
        end
    end

    // The read bus is driven only on address steps 0..3 and only while the
    // grant is present, so a grant loss releases it in the same cycle.
    assign drive           = (state == READ) && bus_gnt && (step != 3'd4);
    assign MACRO_RD_SELECT = drive ? cur_mask : '0;
    assign HASH_ADDR       = drive ? (NONCE_BASE + {3'b000, step}) : '0;
    assign bus_req         = (state == READ);

    // Edge detection, pending bookkeeping and the read sequencer.
    // Reset loads avail_q from the live DATA_AVAILABLE so that a level
    // already high across reset is not mistaken for a new result.
    always_ff @(posedge SPI_CLK) begin
        if (RST) begin
            state       <= IDLE;
            avail_q     <= DATA_AVAILABLE;
            pending     <= '0;
            cur         <= '0;
            last_served <= ID_W'(NUMBER_OF_MACROS - 1);
            step        <= 3'd0;
            nonce       <= 32'd0;
        end else begin
            avail_q <= DATA_AVAILABLE;
            pending <= (pending & ~clear_mask) | rise;
            case (state)
                IDLE: begin
                    step  <= 3'd0;
                    nonce <= 32'd0;
                    if (pick_found) begin
                        cur   <= pick;
                        state <= READ;
                    end
                end
                READ: begin
                    if (!bus_gnt) begin
                        step  <= 3'd0;
                        nonce <= 32'd0;
                        state <= IDLE;
                    end else begin
                        case (step)
                            3'd1:    nonce[7:0]   <= DATA_FROM_HASH;
                            3'd2:    nonce[15:8]  <= DATA_FROM_HASH;
                            3'd3:    nonce[23:16] <= DATA_FROM_HASH;
                            3'd4:    nonce[31:24] <= DATA_FROM_HASH;
                            default: ;
                        endcase
                        if (step == 3'd4) begin
                            step  <= 3'd0;
                            state <= PUSH;
                        end else begin
                            step <= step + 3'd1;
                        end
                    end
                end
                PUSH: begin
                    last_served <= cur;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO control: a full FIFO still accepts a push when the head is popped
    // in the same cycle.
    assign empty     = (wptr == rptr);
    assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop    = result_pop && !empty;
    assign do_push   = (state == PUSH) && (!full || do_pop);
    assign drop      = (state == PUSH) && !do_push;
    assign wptr_next = wptr + {{AW{1'b0}}, do_push};
    assign rptr_next = rptr + {{AW{1'b0}}, do_pop};

    // Pointers, sticky overflow and the registered interrupt.
    always_ff @(posedge SPI_CLK) begin
        if (RST) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
            irq      <= 1'b0;
        end else begin
            wptr <= wptr_next;
            rptr <= rptr_next;
            irq  <= (wptr_next != rptr_next);
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    // Entry storage needs no reset: the head outputs are masked while empty.
    always_ff @(posedge SPI_CLK) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= {cur, nonce};
        end
    end

    assign result_valid = !empty;
    assign fifo_count   = COUNT_W'(wptr - rptr);
    assign result_nonce = empty ? 32'd0 : mem[rptr[AW-1:0]][31:0];
    assign result_macro = empty ? '0 : mem[rptr[AW-1:0]][ID_W+31:32];

endmodule

// File: tb/tb_nonce_collector.sv
// Directed testbench for nonce_collector. A small macro model answers reads
// from a fixed per-macro nonce table one cycle after select/address.
module tb_nonce_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  data_available = 4'b0000;
    logic [7:0]  data_from_hash;
    logic [3:0]  macro_rd_select;
    logic [5:0]  hash_addr;
    logic        bus_req;
    logic        bus_gnt = 1'b1;
    logic        result_valid;
    logic [31:0] result_nonce;
    logic [1:0]  result_macro;
    logic        result_pop = 1'b0;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic        overflow_clear = 1'b0;
    logic        irq;

    int tests    = 0;
    int failures = 0;

    logic [31:0] nonce_tbl [4] = '{32'hDEADBEEF, 32'h44332211, 32'hCAFEF00D, 32'h12345678};
    logic [3:0]  sel_q  = 4'b0000;
    logic [5:0]  addr_q = 6'h00;

    always #5 clk = ~clk;

    nonce_collector dut (
        .SPI_CLK         (clk),
        .RST             (rst),
        .DATA_AVAILABLE  (data_available),
        .DATA_FROM_HASH  (data_from_hash),
        .MACRO_RD_SELECT (macro_rd_select),
        .HASH_ADDR       (hash_addr),
        .bus_req         (bus_req),
        .bus_gnt         (bus_gnt),
        .result_valid    (result_valid),
        .result_nonce    (result_nonce),
        .result_macro    (result_macro),
        .result_pop      (result_pop),
        .fifo_count      (fifo_count),
        .overflow        (overflow),
        .overflow_clear  (overflow_clear),
        .irq             (irq)
    );

    // Macro read model: remember last cycle's select/address, answer from the table.
    always @(posedge clk) begin
        sel_q  <= macro_rd_select;
        addr_q <= hash_addr;
    end

    function automatic logic [7:0] lookup(input logic [3:0] sel, input logic [5:0] addr);
        logic [31:0] word;
        logic [7:0]  b;
        b = 8'h00;
        for (int m = 0; m < 4; m++) begin
            if (sel == (4'b0001 << m)) begin
                word = nonce_tbl[m];
                case (addr)
                    6'h3C:   b = word[7:0];
                    6'h3D:   b = word[15:8];
                    6'h3E:   b = word[23:16];
                    6'h3F:   b = word[31:24];
                    default: b = 8'h00;
                endcase
            end
        end
        return b;
    endfunction

    assign data_from_hash = lookup(sel_q, addr_q);

    task automatic applyStimulus(input logic [3:0] da, input logic gnt,
                                 input logic pop, input logic clr);
        data_available = da;
        bus_gnt        = gnt;
        result_pop     = pop;
        overflow_clear = clr;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " sel"},      32'(macro_rd_select), 32'h0);
        checkOutput({tag, " addr"},     32'(hash_addr),       32'h0);
        checkOutput({tag, " bus_req"},  32'(bus_req),         32'h0);
        checkOutput({tag, " valid"},    32'(result_valid),    32'h0);
        checkOutput({tag, " nonce"},    result_nonce,         32'h0);
        checkOutput({tag, " macro"},    32'(result_macro),    32'h0);
        checkOutput({tag, " count"},    32'(fifo_count),      32'h0);
        checkOutput({tag, " overflow"}, 32'(overflow),        32'h0);
        checkOutput({tag, " irq"},      32'(irq),             32'h0);
    endtask

    task automatic popOnce(input logic [3:0] da);
        applyStimulus(da, 1'b1, 1'b1, 1'b0);
        waitCycles(1);
        applyStimulus(da, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic pulseReset;
        rst = 1'b1;
        waitCycles(1);
        rst = 1'b0;
    endtask

    initial begin
        // Reset values
        waitCycles(1);
        checkAllZero("reset");
        waitCycles(1);
        rst = 1'b0;

        // Single result from macro 1
        waitCycles(1);
        applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0);
        waitCycles(2);
        checkOutput("single step0 addr", 32'(hash_addr),       32'h3C);
        checkOutput("single step0 sel",  32'(macro_rd_select), 32'h2);
        checkOutput("single bus_req",    32'(bus_req),         32'h1);
        waitCycles(1);
        checkOutput("single step1 addr", 32'(hash_addr),       32'h3D);
        waitCycles(4);
        checkOutput("single push no req", 32'(bus_req),        32'h0);
        checkOutput("single push valid",  32'(result_valid),   32'h0);
        waitCycles(1);
        checkOutput("single valid", 32'(result_valid), 32'h1);
        checkOutput("single nonce", result_nonce,      32'h44332211);
        checkOutput("single macro", 32'(result_macro), 32'h1);
        checkOutput("single irq",   32'(irq),          32'h1);
        checkOutput("single count", 32'(fifo_count),   32'h1);
        popOnce(4'b0010);
        checkOutput("single pop count", 32'(fifo_count),   32'h0);
        checkOutput("single pop irq",   32'(irq),          32'h0);
        checkOutput("single pop valid", 32'(result_valid), 32'h0);
        waitCycles(20);
        checkOutput("single held no dup", 32'(fifo_count), 32'h0);

        // Round-robin from a fresh reset: 0, 2, 3
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
        pulseReset();
        waitCycles(1);
        applyStimulus(4'b1101, 1'b1, 1'b0, 1'b0);
        waitCycles(25);
        checkOutput("rr count", 32'(fifo_count), 32'h3);
        checkOutput("rr head0 macro", 32'(result_macro), 32'h0);
        checkOutput("rr head0 nonce", result_nonce,      32'hDEADBEEF);
        popOnce(4'b1101);
        checkOutput("rr head1 macro", 32'(result_macro), 32'h2);
        checkOutput("rr head1 nonce", result_nonce,      32'hCAFEF00D);
        popOnce(4'b1101);
        checkOutput("rr head2 macro", 32'(result_macro), 32'h3);
        checkOutput("rr head2 nonce", result_nonce,      32'h12345678);
        popOnce(4'b1101);
        checkOutput("rr drained", 32'(fifo_count), 32'h0);

        // After serving 3, a joint rise of 0 and 3 yields 0 then 3
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
        waitCycles(2);
        applyStimulus(4'b1001, 1'b1, 1'b0, 1'b0);
        waitCycles(20);
        checkOutput("rr2 count", 32'(fifo_count), 32'h2);
        checkOutput("rr2 head0 macro", 32'(result_macro), 32'h0);
        popOnce(4'b1001);
        checkOutput("rr2 head1 macro", 32'(result_macro), 32'h3);
        popOnce(4'b1001);
        waitCycles(15);
        checkOutput("rr2 held no dup", 32'(fifo_count), 32'h0);

        // Overflow: four fill the FIFO, the fifth is dropped
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
        waitCycles(2);
        applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0);
        waitCycles(30);
        checkOutput("ovf fill count", 32'(fifo_count), 32'h4);
        checkOutput("ovf fill flag",  32'(overflow),   32'h0);
        applyStimulus(4'b1110, 1'b1, 1'b0, 1'b0);
        waitCycles(2);
        applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0);
        waitCycles(10);
        checkOutput("ovf drop count", 32'(fifo_count),   32'h4);
        checkOutput("ovf drop flag",  32'(overflow),     32'h1);
        checkOutput("ovf head macro", 32'(result_macro), 32'h0);
        checkOutput("ovf head nonce", result_nonce,      32'hDEADBEEF);
        checkOutput("ovf irq",        32'(irq),          32'h1);
        applyStimulus(4'b1111, 1'b1, 1'b0, 1'b1);
        waitCycles(1);
        applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0);
        checkOutput("ovf clear", 32'(overflow), 32'h0);

        // Push while full, with a pop in the PUSH cycle, is accepted
        applyStimulus(4'b1101, 1'b1, 1'b0, 1'b0);
        waitCycles(2);
        applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0);
        waitCycles(7);
        checkOutput("full+pop in push", 32'(bus_req), 32'h0);
        applyStimulus(4'b1111, 1'b1, 1'b1, 1'b0);
        waitCycles(1);
        applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0);
        checkOutput("full+pop count", 32'(fifo_count),   32'h4);
        checkOutput("full+pop flag",  32'(overflow),     32'h0);
        checkOutput("full+pop head",  32'(result_macro), 32'h1);
        popOnce(4'b1111);
        checkOutput("drain head 2", 32'(result_macro), 32'h2);
        popOnce(4'b1111);
        checkOutput("drain head 3", 32'(result_macro), 32'h3);
        popOnce(4'b1111);
        checkOutput("drain new macro", 32'(result_macro), 32'h1);
        checkOutput("drain new nonce", result_nonce,      32'h44332211);
        checkOutput("drain new count", 32'(fifo_count),   32'h1);
        popOnce(4'b1111);
        checkOutput("drain empty", 32'(fifo_count), 32'h0);

        // Grant loss at READ step 2
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
        pulseReset();
        waitCycles(1);
        applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
        waitCycles(4);
        checkOutput("gnt step2 addr", 32'(hash_addr), 32'h3E);
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("gnt lost sel",  32'(macro_rd_select), 32'h0);
        checkOutput("gnt lost addr", 32'(hash_addr),       32'h0);
        waitCycles(1);
        checkOutput("gnt lost idle", 32'(bus_req), 32'h0);
        applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
        waitCycles(1);
        checkOutput("gnt reread addr", 32'(hash_addr),       32'h3C);
        checkOutput("gnt reread sel",  32'(macro_rd_select), 32'h4);
        waitCycles(6);
        checkOutput("gnt count", 32'(fifo_count),   32'h1);
        checkOutput("gnt nonce", result_nonce,      32'hCAFEF00D);
        checkOutput("gnt macro", 32'(result_macro), 32'h2);
        waitCycles(15);
        checkOutput("gnt once", 32'(fifo_count), 32'h1);

        // Reset at READ step 3 (FIFO still holds the entry above)
        applyStimulus(4'b1100, 1'b1, 1'b0, 1'b0);
        waitCycles(5);
        checkOutput("rst step3 addr", 32'(hash_addr),       32'h3F);
        checkOutput("rst step3 sel",  32'(macro_rd_select), 32'h8);
        rst = 1'b1;
        waitCycles(1);
        checkAllZero("midread reset");
        rst = 1'b0;
        waitCycles(20);
        checkOutput("post reset held", 32'(fifo_count), 32'h0);
        checkOutput("post reset idle", 32'(bus_req),    32'h0);
        applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
        waitCycles(2);
        applyStimulus(4'b1100, 1'b1, 1'b0, 1'b0);
        waitCycles(8);
        checkOutput("rerise count", 32'(fifo_count),   32'h1);
        checkOutput("rerise macro", 32'(result_macro), 32'h3);
        checkOutput("rerise nonce", result_nonce,      32'h12345678);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
